// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard producing the ID-stage RAW/saturation stall.
// Define SCOREBOARD_WB_BYPASS_EN to let a same-cycle writeback release a count-of-one source.
module reg_scoreboard #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned CNT_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [ADDR_W-1:0]       rs1_addr_id,
    input  logic [ADDR_W-1:0]       rs2_addr_id,
    input  logic                    rs1_used,
    input  logic                    rs2_used,
    input  logic [ADDR_W-1:0]       rd_addr_id,
    input  logic                    reg_write_id,
    input  logic                    issue,
    input  logic                    kill_valid,
    input  logic [ADDR_W-1:0]       kill_rd,
    input  logic                    wb_valid,
    input  logic [ADDR_W-1:0]       wb_rd,
    input  logic                    clear_all,
    output logic                    stall_id,
    output logic [NUM_REGS-1:0]     busy_vec,
    output logic [ADDR_W+CNT_W-1:0] pending_total,
    output logic                    err_underflow
);

    localparam int unsigned TotW   = ADDR_W + CNT_W;
    localparam int          CntMax = (1 << CNT_W) - 1;

    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];
    logic [TotW-1:0]  total_q, total_d;
    logic             err_q, err_d;
    logic             underflow;
    logic             rs1_busy, rs2_busy, rd_sat;

    // Net all same-cycle events per register, clamping at both ends of the counter range.
    always_comb begin
        int sum;
        int dec;
        sum       = 0;
        dec       = 0;
        cnt_d     = cnt_q;
        underflow = 1'b0;
        total_d   = '0;
        cnt_d[0]  = '0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            sum = int'(cnt_q[r]);
            if (issue && reg_write_id && rd_addr_id == ADDR_W'(r)) sum = sum + 1;
            dec = 0;
            if (wb_valid && wb_rd == ADDR_W'(r)) dec = dec + 1;
            if (kill_valid && kill_rd == ADDR_W'(r)) dec = dec + 1;
            if (dec > sum) begin
                underflow = 1'b1;
                sum       = 0;
            end else begin
                sum = sum - dec;
            end
            if (sum > CntMax) sum = CntMax;
            cnt_d[r] = clear_all ? '0 : CNT_W'(sum);
            total_d  = total_d + TotW'(cnt_d[r]);
        end
        // A drain discards the same-cycle events, so they cannot underflow either.
        if (clear_all) underflow = 1'b0;
        err_d = err_q | underflow;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) cnt_q[i] <= '0;
            total_q <= '0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            total_q <= total_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) busy_vec[i] = (cnt_q[i] != '0);
    end

    always_comb begin
        rs1_busy = (rs1_addr_id != '0) && (cnt_q[rs1_addr_id] != '0);
        rs2_busy = (rs2_addr_id != '0) && (cnt_q[rs2_addr_id] != '0);
`ifdef SCOREBOARD_WB_BYPASS_EN
        // Register file writes before it reads: the last pending write lands this cycle.
        if (wb_valid && wb_rd == rs1_addr_id && cnt_q[rs1_addr_id] == CNT_W'(1)) rs1_busy = 1'b0;
        if (wb_valid && wb_rd == rs2_addr_id && cnt_q[rs2_addr_id] == CNT_W'(1)) rs2_busy = 1'b0;
`endif
        rd_sat   = (rd_addr_id != '0) && (cnt_q[rd_addr_id] == CNT_W'(CntMax));
        stall_id = id_valid && ((rs1_used && rs1_busy) || (rs2_used && rs2_busy) ||
                                (reg_write_id && rd_sat));
    end

    assign pending_total = total_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, rs1_used, rs2_used, reg_write_id, issue, kill_valid, wb_valid, clear_all;
    logic [4:0]  rs1_addr_id, rs2_addr_id, rd_addr_id, kill_rd, wb_rd;
    logic        stall_id, err_underflow;
    logic [31:0] busy_vec;
    logic [6:0]  pending_total;

    int n_vec  = 0;
    int n_miss = 0;

    reg_scoreboard dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .rs1_addr_id   (rs1_addr_id),
        .rs2_addr_id   (rs2_addr_id),
        .rs1_used      (rs1_used),
        .rs2_used      (rs2_used),
        .rd_addr_id    (rd_addr_id),
        .reg_write_id  (reg_write_id),
        .issue         (issue),
        .kill_valid    (kill_valid),
        .kill_rd       (kill_rd),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .clear_all     (clear_all),
        .stall_id      (stall_id),
        .busy_vec      (busy_vec),
        .pending_total (pending_total),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; id_valid = 1'b0; rs1_used = 1'b0; rs2_used = 1'b0; reg_write_id = 1'b0;
        issue = 1'b0; kill_valid = 1'b0; wb_valid = 1'b0; clear_all = 1'b0;
        rs1_addr_id = '0; rs2_addr_id = '0; rd_addr_id = '0; kill_rd = '0; wb_rd = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_vec++; if (busy_vec !== 32'h0) begin n_miss++; $display("FAIL reset_busy: got %h want 0", busy_vec); end
        n_vec++; if (pending_total !== 7'd0) begin n_miss++; $display("FAIL reset_total: got %0d want 0", pending_total); end
        n_vec++; if (stall_id !== 1'b0) begin n_miss++; $display("FAIL reset_stall: got %b want 0", stall_id); end
        n_vec++; if (err_underflow !== 1'b0) begin n_miss++; $display("FAIL reset_err: got %b want 0", err_underflow); end
    endtask

    task automatic test_raw();
        idle_inputs();
        id_valid = 1'b1; reg_write_id = 1'b1; rd_addr_id = 5'd5; issue = 1'b1;
        tick();
        issue = 1'b0; reg_write_id = 1'b0; rd_addr_id = '0; rs1_addr_id = 5'd5; rs1_used = 1'b1;
        #1;
        n_vec++; if (stall_id !== 1'b1) begin n_miss++; $display("FAIL raw_stall_n1: got %b want 1", stall_id); end
        n_vec++; if (busy_vec !== 32'h20) begin n_miss++; $display("FAIL raw_busy: got %h want 00000020", busy_vec); end
        n_vec++; if (pending_total !== 7'd1) begin n_miss++; $display("FAIL raw_total: got %0d want 1", pending_total); end
        tick();
        n_vec++; if (stall_id !== 1'b1) begin n_miss++; $display("FAIL raw_stall_n2: got %b want 1", stall_id); end
        wb_valid = 1'b1; wb_rd = 5'd5;
        #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
        n_vec++; if (stall_id !== 1'b0) begin n_miss++; $display("FAIL raw_wb_cycle: got %b want 0", stall_id); end
`else
        n_vec++; if (stall_id !== 1'b1) begin n_miss++; $display("FAIL raw_wb_cycle: got %b want 1", stall_id); end
`endif
        tick();
        wb_valid = 1'b0; wb_rd = '0;
        #1;
        n_vec++; if (stall_id !== 1'b0) begin n_miss++; $display("FAIL raw_after_wb: got %b want 0", stall_id); end
        n_vec++; if (pending_total !== 7'd0) begin n_miss++; $display("FAIL raw_drained: got %0d want 0", pending_total); end
    endtask

    task automatic test_x0_unused();
        idle_inputs();
        id_valid = 1'b1; reg_write_id = 1'b1; rd_addr_id = 5'd0; issue = 1'b1;
        tick();
        issue = 1'b0; reg_write_id = 1'b0; rs1_addr_id = 5'd0; rs1_used = 1'b1;
        #1;
        n_vec++; if (busy_vec !== 32'h0) begin n_miss++; $display("FAIL x0_busy: got %h want 0", busy_vec); end
        n_vec++; if (pending_total !== 7'd0) begin n_miss++; $display("FAIL x0_total: got %0d want 0", pending_total); end
        n_vec++; if (stall_id !== 1'b0) begin n_miss++; $display("FAIL x0_stall: got %b want 0", stall_id); end
        // Writeback against x0 must not count as an underflow.
        wb_valid = 1'b1; wb_rd = 5'd0; rs1_used = 1'b0;
        tick();
        wb_valid = 1'b0;
        n_vec++; if (err_underflow !== 1'b0) begin n_miss++; $display("FAIL x0_wb_err: got %b want 0", err_underflow); end
        reg_write_id = 1'b1; rd_addr_id = 5'd7; issue = 1'b1;
        tick();
        issue = 1'b0; reg_write_id = 1'b0; rs2_addr_id = 5'd7; rs2_used = 1'b0;
        #1;
        n_vec++; if (busy_vec !== 32'h80) begin n_miss++; $display("FAIL unused_busy: got %h want 00000080", busy_vec); end
        n_vec++; if (stall_id !== 1'b0) begin n_miss++; $display("FAIL unused_rs2: got %b want 0", stall_id); end
        rs2_used = 1'b1;
        #1;
        n_vec++; if (stall_id !== 1'b1) begin n_miss++; $display("FAIL used_rs2: got %b want 1", stall_id); end
        rs2_used = 1'b0; wb_valid = 1'b1; wb_rd = 5'd7;
        tick();
        wb_valid = 1'b0;
        n_vec++; if (pending_total !== 7'd0) begin n_miss++; $display("FAIL unused_drain: got %0d want 0", pending_total); end
    endtask

    task automatic test_saturation();
        idle_inputs();
        reg_write_id = 1'b1; rd_addr_id = 5'd9; issue = 1'b1;
        tick();
        tick();
        tick();
        issue = 1'b0; id_valid = 1'b1;
        #1;
        n_vec++; if (pending_total !== 7'd3) begin n_miss++; $display("FAIL sat_total: got %0d want 3", pending_total); end
        n_vec++; if (busy_vec !== 32'h200) begin n_miss++; $display("FAIL sat_busy: got %h want 00000200", busy_vec); end
        n_vec++; if (stall_id !== 1'b1) begin n_miss++; $display("FAIL sat_stall: got %b want 1", stall_id); end
        id_valid = 1'b0;
        #1;
        n_vec++; if (stall_id !== 1'b0) begin n_miss++; $display("FAIL sat_no_valid: got %b want 0", stall_id); end
        // Issue while saturated: count holds at max, no wrap, no error.
        issue = 1'b1;
        tick();
        issue = 1'b0;
        n_vec++; if (pending_total !== 7'd3) begin n_miss++; $display("FAIL sat_nowrap: got %0d want 3", pending_total); end
        n_vec++; if (err_underflow !== 1'b0) begin n_miss++; $display("FAIL sat_err: got %b want 0", err_underflow); end
        wb_valid = 1'b1; wb_rd = 5'd9;
        tick();
        wb_valid = 1'b0; id_valid = 1'b1;
        #1;
        n_vec++; if (stall_id !== 1'b0) begin n_miss++; $display("FAIL sat_release: got %b want 0", stall_id); end
        n_vec++; if (pending_total !== 7'd2) begin n_miss++; $display("FAIL sat_after_wb: got %0d want 2", pending_total); end
        id_valid = 1'b0; wb_valid = 1'b1;
        tick();
        tick();
        wb_valid = 1'b0;
        n_vec++; if (pending_total !== 7'd0) begin n_miss++; $display("FAIL sat_drain: got %0d want 0", pending_total); end
    endtask

    task automatic test_simultaneous();
        idle_inputs();
        reg_write_id = 1'b1; rd_addr_id = 5'd4; issue = 1'b1;
        tick();
        tick();
        issue = 1'b0;
        n_vec++; if (pending_total !== 7'd2) begin n_miss++; $display("FAIL sim_two: got %0d want 2", pending_total); end
        wb_valid = 1'b1; wb_rd = 5'd4; kill_valid = 1'b1; kill_rd = 5'd4;
        tick();
        wb_valid = 1'b0; kill_valid = 1'b0;
        n_vec++; if (pending_total !== 7'd0) begin n_miss++; $display("FAIL sim_wb_kill: got %0d want 0", pending_total); end
        n_vec++; if (err_underflow !== 1'b0) begin n_miss++; $display("FAIL sim_wb_kill_err: got %b want 0", err_underflow); end
        issue = 1'b1;
        tick();
        wb_valid = 1'b1;
        tick();
        n_vec++; if (busy_vec !== 32'h10 || pending_total !== 7'd1) begin
            n_miss++; $display("FAIL sim_issue_wb: got busy %h total %0d want 00000010 1", busy_vec, pending_total);
        end
        kill_valid = 1'b1;
        tick();
        issue = 1'b0; kill_valid = 1'b0;
        n_vec++; if (pending_total !== 7'd0) begin n_miss++; $display("FAIL sim_all_three: got %0d want 0", pending_total); end
        n_vec++; if (err_underflow !== 1'b0) begin n_miss++; $display("FAIL sim_all_three_err: got %b want 0", err_underflow); end
        tick();
        wb_valid = 1'b0;
        n_vec++; if (pending_total !== 7'd0) begin n_miss++; $display("FAIL under_clamp: got %0d want 0", pending_total); end
        n_vec++; if (err_underflow !== 1'b1) begin n_miss++; $display("FAIL under_err: got %b want 1", err_underflow); end
        tick();
        n_vec++; if (err_underflow !== 1'b1) begin n_miss++; $display("FAIL under_sticky: got %b want 1", err_underflow); end
    endtask

    task automatic test_clear_all();
        idle_inputs();
        reg_write_id = 1'b1; issue = 1'b1; rd_addr_id = 5'd3;
        tick();
        rd_addr_id = 5'd12;
        tick();
        issue = 1'b0;
        n_vec++; if (busy_vec !== 32'h1008) begin n_miss++; $display("FAIL clr_pre: got %h want 00001008", busy_vec); end
        issue = 1'b1; rd_addr_id = 5'd3; clear_all = 1'b1;
        tick();
        issue = 1'b0; clear_all = 1'b0;
        n_vec++; if (busy_vec !== 32'h0) begin n_miss++; $display("FAIL clr_busy: got %h want 0", busy_vec); end
        n_vec++; if (pending_total !== 7'd0) begin n_miss++; $display("FAIL clr_total: got %0d want 0", pending_total); end
        n_vec++; if (err_underflow !== 1'b1) begin n_miss++; $display("FAIL clr_keeps_err: got %b want 1", err_underflow); end
        // Reset mid-operation discards pending state and the sticky error.
        issue = 1'b1; rd_addr_id = 5'd3;
        tick();
        issue = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (busy_vec !== 32'h0 || pending_total !== 7'd0) begin
            n_miss++; $display("FAIL rst_mid: got busy %h total %0d want 0 0", busy_vec, pending_total);
        end
        n_vec++; if (err_underflow !== 1'b0) begin n_miss++; $display("FAIL rst_mid_err: got %b want 0", err_underflow); end
    endtask

    initial begin
        test_reset();
        test_raw();
        test_x0_unused();
        test_saturation();
        test_simultaneous();
        test_clear_all();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Per-register pending-write scoreboard for the 5-stage RV64I pipeline.
- Tracks in-flight writes from issue (ID->EX transfer) to writeback. Produces the ID-stage stall for RAW hazards and for pending-count saturation.
- Replaces per-stage rd comparison, so stall decisions no longer depend on pipeline depth or on multi-cycle units.
- Sits beside the decode stage. Its stall_id output feeds the IF/ID hold and the ID/EX bubble logic.

Parameters:
- NUM_REGS, 32, number of architectural integer registers; x0 is never tracked.
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W.
- CNT_W, 2, width of the per-register pending counter; maximum count is 2**CNT_W-1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID stage holds a valid instruction
- rs1_addr_id  in  ADDR_W  source register 1 of the ID instruction
- rs2_addr_id  in  ADDR_W  source register 2 of the ID instruction
- rs1_used  in  1  ID instruction reads rs1
- rs2_used  in  1  ID instruction reads rs2
- rd_addr_id  in  ADDR_W  destination register of the ID instruction
- reg_write_id  in  1  ID instruction writes rd
- issue  in  1  ID instruction moves into EX this cycle; asserted only when stall_id=0
- kill_valid  in  1  an instruction already issued is squashed this cycle (ID/EX flush)
- kill_rd  in  ADDR_W  destination register of the squashed instruction
- wb_valid  in  1  WB retires an instruction with a register write this cycle
- wb_rd  in  ADDR_W  destination register written in WB
- clear_all  in  1  trap/redirect drain: discard all pending state
- stall_id  out  1  hold IF/ID and inject a bubble into ID/EX
- busy_vec  out  NUM_REGS  bit i = pending count of register i is non-zero (bit 0 always 0)
- pending_total  out  ADDR_W+CNT_W  sum of all pending counts
- err_underflow  out  1  sticky: a writeback or kill occurred against a zero count

Behaviour:
- State: one CNT_W counter per register 1..NUM_REGS-1, plus a sticky error flag. All state is registered on clk.
- Reset (rst=1): all counts 0, err_underflow 0. Hence busy_vec=0, pending_total=0 and stall_id=0 in the first cycle after reset. Reset mid-operation discards all pending state.
- Per-register delta for register r in a cycle:
  - inc = issue & reg_write_id & (rd_addr_id==r)
  - dec_wb = wb_valid & (wb_rd==r)
  - dec_k = kill_valid & (kill_rd==r)
  - next = count + inc - dec_wb - dec_k
- Register x0: every event against x0 is ignored.
- Simultaneous events on the same register net out in one cycle:
  - issue + wb -> unchanged
  - wb + kill -> -2
  - issue + wb + kill -> -1
- Underflow: if the decrements exceed count + inc, the count clamps to 0 and err_underflow sets. err_underflow clears only on rst.
- clear_all: all counts become 0 next cycle. It has priority over same-cycle issue, wb and kill. err_underflow is unaffected.
- Stall (combinational from current counts and ID inputs):
  - raw = id_valid & ((rs1_used & rs1_addr_id!=0 & busy[rs1]) | (rs2_used & rs2_addr_id!=0 & busy[rs2]))
  - sat = id_valid & reg_write_id & rd_addr_id!=0 & count[rd]==max
  - stall_id = raw | sat
- Latency: an issue in cycle N is visible in busy_vec and stall_id from cycle N+1. A writeback in cycle N clears the hazard from N+1, unless the optional feature below is compiled in.
- issue while stall_id=1 is a protocol violation. The count still increments and saturates at max (no wrap); no error is flagged.
- pending_total is registered and reflects the counts after the same edge.

Optional Feature:
- Macro: SCOREBOARD_WB_BYPASS_EN.
- Defined: the register file writes before it reads. A source register is not treated as busy when wb_valid=1, wb_rd equals that source register, and its current count is 1. stall_id drops in the writeback cycle itself, saving one stall cycle per dependent writeback.
- Not defined: a source counts as busy whenever its count is non-zero, regardless of same-cycle writeback.

Test Plan:
- Reset then idle: rst high 2 cycles, all inputs 0 -> busy_vec=0, pending_total=0, stall_id=0, err_underflow=0.
- RAW stall: issue rd=5; next cycle ID reads rs1=5 (rs1_used=1) -> stall_id=1 until wb_valid rd=5. Without the macro, stall_id=0 the cycle after wb. With SCOREBOARD_WB_BYPASS_EN, stall_id=0 in the wb cycle itself.
- x0 and unused sources: issue rd=0; ID reads rs1=0, and separately ID has rs2=7 busy with rs2_used=0 -> stall_id=0, busy_vec[0]=0.
- Saturation with CNT_W=2: three issues to rd=9 -> count 3, pending_total=3. ID with rd=9, reg_write_id=1 -> stall_id=1. One wb to rd=9 -> stall_id=0 next cycle.
- Simultaneous events: rd=4 count 1. Same cycle: issue rd=4, wb rd=4, kill rd=4 -> count 0, no error. Then wb rd=4 -> count stays 0, err_underflow=1 and stays 1.
- clear_all: counts on x3 and x12. Assert clear_all together with issue rd=3 -> next cycle busy_vec=0, pending_total=0.
